// File: rtl/instr_decode_unit.sv
// Decode stage feeding the d16 register file: collects word0 (+ optional immediate word)
// and presents a registered bundle. Define DECODE_ILLEGAL_TRAP_EN to trap opcodes >= OPCODE_COUNT.
//
//   state  | meaning
//   S_OP   | waiting for instruction word0
//   S_IMM  | word0 latched, waiting for immediate word1
//   S_HOLD | decoded bundle valid, held until execute accepts
module instr_decode_unit #(
    parameter int OPCODE_COUNT = 32,
    parameter int IMM_BIT      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_word,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_opcode,
    output logic        out_has_imm,
    output logic [15:0] out_imm,
    output logic [2:0]  rf_rD_sel,
    output logic [2:0]  rf_rS_sel,
    output logic        rf_en,
    output logic        illegal
);

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [1:0] S_OP   = 2'd0;
    localparam logic [1:0] S_IMM  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [8:0] OPC_LIM = 9'(OPCODE_COUNT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic        has_imm_q, has_imm_d;
    logic [15:0] imm_q, imm_d;
    logic [2:0]  rd_q, rd_d;
    logic [2:0]  rs_q, rs_d;
    logic        illegal_q, illegal_d;
    logic        take_w0;
    logic        op_bad;
    logic        unused_rsvd;

    // bit 6 of word0 is reserved and intentionally not decoded
    assign unused_rsvd = in_word[6];

    assign out_valid = (state_q == S_HOLD);
    assign in_ready  = (state_q != S_HOLD) | out_ready;
    assign rf_en     = out_valid & out_ready & ~flush;
    assign op_bad    = ({1'b0, in_word[15:8]} >= OPC_LIM);

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        has_imm_d = has_imm_q;
        imm_d     = imm_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        illegal_d = 1'b0;
        take_w0   = 1'b0;

        if (flush) begin
            state_d = S_OP;
        end else begin
            case (state_q)
                S_OP:   take_w0 = in_valid;
                S_IMM: begin
                    if (in_valid) begin
                        imm_d   = in_word;
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_d = S_OP;
                        take_w0 = in_valid;
                    end
                end
                default: state_d = S_OP;
            endcase
        end

        // trapped word0 is consumed without touching the held bundle fields
        if (take_w0) begin
            if (TRAP_EN && op_bad) begin
                state_d   = S_OP;
                illegal_d = 1'b1;
            end else begin
                opcode_d  = in_word[15:8];
                has_imm_d = in_word[IMM_BIT];
                imm_d     = 16'h0000;
                rs_d      = in_word[5:3];
                rd_d      = in_word[2:0];
                state_d   = in_word[IMM_BIT] ? S_IMM : S_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OP;
            opcode_q  <= 8'h00;
            has_imm_q <= 1'b0;
            imm_q     <= 16'h0000;
            rd_q      <= 3'd0;
            rs_q      <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            has_imm_q <= has_imm_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_opcode  = opcode_q;
    assign out_has_imm = has_imm_q;
    assign out_imm     = imm_q;
    assign rf_rD_sel   = rd_q;
    assign rf_rS_sel   = rs_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Bench for instr_decode_unit: table-driven instruction vectors with a bundle scoreboard,
// plus directed hold / flush / reset / illegal-opcode sequences.
module tb_instr_decode_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_word = 16'h0000;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_opcode;
    logic        out_has_imm;
    logic [15:0] out_imm;
    logic [2:0]  rf_rD_sel;
    logic [2:0]  rf_rS_sel;
    logic        rf_en;
    logic        illegal;

    instr_decode_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_has_imm (out_has_imm),
        .out_imm     (out_imm),
        .rf_rD_sel   (rf_rD_sel),
        .rf_rS_sel   (rf_rS_sel),
        .rf_en       (rf_en),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  op;
        logic        hi;
        logic [15:0] imm;
        logic [2:0]  rd;
        logic [2:0]  rs;
    } bundle_t;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        int          gap;
        bundle_t     exp;
    } vec_t;

    bundle_t exp_q[$];
    vec_t    vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: bundles are compared on every transfer-out
    always @(negedge clk) begin
        if (rst_n) begin
            check("rf_en", {63'd0, rf_en}, {63'd0, out_valid & out_ready & ~flush});
`ifndef DECODE_ILLEGAL_TRAP_EN
            check("illegal_tied", {63'd0, illegal}, 64'd0);
`endif
            if (out_valid && out_ready && !flush) begin
                check("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    bundle_t e;
                    e = exp_q.pop_front();
                    check("bundle", {33'd0, out_opcode, out_has_imm, out_imm, rf_rD_sel, rf_rS_sel},
                          {33'd0, e});
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return {30'd0, out_valid, out_opcode, out_has_imm, out_imm, rf_rD_sel, rf_rS_sel, rf_en, illegal};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        vecs[0] = '{16'h0311, 16'h0000, 0, '{8'h03, 1'b0, 16'h0000, 3'd1, 3'd2}};
        vecs[1] = '{16'h0A2B, 16'h0000, 0, '{8'h0A, 1'b0, 16'h0000, 3'd3, 3'd5}};
        vecs[2] = '{16'h0582, 16'hBEEF, 0, '{8'h05, 1'b1, 16'hBEEF, 3'd2, 3'd0}};
        vecs[3] = '{16'h0582, 16'hBEEF, 3, '{8'h05, 1'b1, 16'hBEEF, 3'd2, 3'd0}};
        vecs[4] = '{16'h007F, 16'h0000, 0, '{8'h00, 1'b0, 16'h0000, 3'd7, 3'd7}};
        vecs[5] = '{16'h1FC5, 16'h1234, 2, '{8'h1F, 1'b1, 16'h1234, 3'd5, 3'd0}};

        #1;
        check("reset_outputs", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // vector table, execute always ready
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            align();
            exp_q.push_back(vecs[i].exp);
            send_word(vecs[i].w0);
            if (vecs[i].w0[7]) begin
                for (int g = 0; g < vecs[i].gap; g++) begin
                    @(negedge clk);
                    check("gap_no_valid", {63'd0, out_valid}, 64'd0);
                    @(posedge clk);
                    #1;
                end
                send_word(vecs[i].w1);
            end
            drain();
        end

        // back-to-back stream of single-word instructions
        align();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] w;
            w = 16'h0311 + 16'(i << 8);
            exp_q.push_back('{w[15:8], 1'b0, 16'h0000, 3'd1, 3'd2});
            send_word(w);
        end
        check("b2b_cycles", 64'(cyc - c0), 64'd4);
        drain();

        // execute stalls for 5 cycles with the next word waiting
        align();
        out_ready = 1'b0;
        send_word(16'h0311);
        in_valid = 1'b1;
        in_word  = 16'h0A2B;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_rf_en", {63'd0, rf_en}, 64'd0);
            check("hold_bundle", {50'd0, out_opcode, rf_rS_sel, rf_rD_sel}, {50'd0, 8'h03, 3'd2, 3'd1});
        end
        align();
        exp_q.push_back('{8'h03, 1'b0, 16'h0000, 3'd1, 3'd2});
        exp_q.push_back('{8'h0A, 1'b0, 16'h0000, 3'd3, 3'd5});
        out_ready = 1'b1;
        send_word(16'h0A2B);
        drain();

        // flush while waiting for the immediate word
        align();
        send_word(16'h0480);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_word  = 16'hDEAD;
        @(negedge clk);
        check("flush_imm_valid", {63'd0, out_valid}, 64'd0);
        align();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("after_flush_valid", {63'd0, out_valid}, 64'd0);
        align();
        exp_q.push_back('{8'h01, 1'b0, 16'h0000, 3'd2, 3'd2});
        send_word(16'h0112);
        drain();

        // flush while a bundle is held
        align();
        out_ready = 1'b0;
        send_word(16'h0311);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush_hold_rf_en", {63'd0, rf_en}, 64'd0);
        align();
        flush = 1'b0;
        @(negedge clk);
        check("flush_hold_valid", {63'd0, out_valid}, 64'd0);

        // opcode at OPCODE_COUNT
        align();
`ifdef DECODE_ILLEGAL_TRAP_EN
        send_word(16'h2000);
        @(negedge clk);
        check("illegal_pulse", {62'd0, illegal, out_valid}, {62'd0, 1'b1, 1'b0});
        @(negedge clk);
        check("illegal_one_cycle", {62'd0, illegal, out_valid}, 64'd0);
        align();
        exp_q.push_back('{8'h03, 1'b0, 16'h0000, 3'd1, 3'd2});
        send_word(16'h2080);
        send_word(16'h0311);
        drain();
`else
        exp_q.push_back('{8'h20, 1'b0, 16'h0000, 3'd0, 3'd0});
        send_word(16'h2000);
        @(negedge clk);
        check("op20_valid", {63'd0, out_valid}, 64'd1);
        check("op20_illegal", {63'd0, illegal}, 64'd0);
        drain();
        align();
        exp_q.push_back('{8'h20, 1'b1, 16'h0311, 3'd0, 3'd0});
        send_word(16'h2080);
        send_word(16'h0311);
        drain();
`endif

        // asynchronous reset while a bundle is held
        align();
        out_ready = 1'b0;
        send_word(16'h0311);
        @(negedge clk);
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 64'd0);
        align();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_valid", {63'd0, out_valid}, 64'd0);
        check("sb_final_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
